txrx_channel: RTL and testbench
===============================

TXRX_CHANNEL -- requirements
Module: txrx_channel

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data width of tx_data, xDATA and rx_data.
REQ-002 SHALL have port ACLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port ARESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port tx_en  input  1  source has a word on tx_data to send.
REQ-005 SHALL have port tx_data  input  WIDTH  source word.
REQ-006 SHALL have port tx_hold  output  1  TX is holding an unaccepted word; source must keep tx_data stable.
REQ-007 SHALL have port VALID  output  1  channel VALID, TX to RX.
REQ-008 SHALL have port xDATA  output  WIDTH  channel data, TX to RX.
REQ-009 SHALL have port READY  output  1  channel READY, RX to TX.
REQ-010 SHALL have port rx_hold  input  1  sink busy; RX must not accept.
REQ-011 SHALL have port rx_data  output  WIDTH  last word received.
REQ-012 SHALL have port rx_new_data  output  1  one-cycle pulse, rx_data just updated.
REQ-013 SHALL have port xfer_count  output  16  completed-transfer count (see Configuration).

Function
REQ-014 SHALL define a handshake as VALID=1 and READY=1 sampled at the same rising ACLK edge.
REQ-015 SHALL drive READY combinationally as (not rx_hold) and (not ARESET).
REQ-016 SHALL, at an edge with VALID=0 or a handshake, load VALID<=tx_en and, if tx_en=1, load xDATA<=tx_data.
REQ-017 SHALL, at an edge with VALID=1 and READY=0, hold VALID and xDATA unchanged regardless of tx_en and tx_data.
REQ-018 SHALL keep VALID asserted after tx_en deasserts until the held word is accepted.
REQ-019 SHALL drive tx_hold combinationally as VALID and (not READY).
REQ-020 SHALL, on a handshake, load rx_data<=xDATA and assert rx_new_data for exactly the following cycle.
REQ-021 SHALL keep rx_data unchanged between handshakes and hold rx_new_data at 0 otherwise.
REQ-022 SHALL sustain one transfer per cycle with tx_en=1 and rx_hold=0, with 1-cycle latency tx_data->xDATA and 1-cycle latency xDATA->rx_data.
REQ-023 SHALL, on a handshake with tx_en=1 at the same edge, load the next word with VALID staying 1.
REQ-024 SHALL never duplicate or drop a word once VALID=1 for it.

Reset
REQ-025 SHALL, while ARESET=1, force VALID=0, xDATA=0, rx_data=0, rx_new_data=0, xfer_count=0, READY=0 and tx_hold=0, asynchronously.
REQ-026 SHALL discard any pending unaccepted word on reset mid-operation and resume at the first edge after ARESET falls.

Configuration
REQ-027 SHALL, with macro TXRX_XFER_COUNT_EN defined, increment xfer_count by 1 per handshake, wrapping 16'hFFFF->0.
REQ-028 SHALL, without TXRX_XFER_COUNT_EN, keep the xfer_count port and tie it to 0, with no counter logic.

Structure
REQ-029 SHALL place the WIDTH default (8) and the counter width (16) as constants in the shared package txrx_pkg.
REQ-030 SHALL implement the RX side (READY, rx_data, rx_new_data) as one sub-module, txrx_rx_stage, with the TX side and counter in the top.

Verification
REQ-031 SHALL verify reset: ARESET=1 with tx_en=1 and tx_data=8'hA5 -> VALID=0, READY=0, rx_data=0, rx_new_data=0.
REQ-032 SHALL verify streaming: tx_en=1, rx_hold=0, tx_data 8'h11, 8'h22, 8'h33 on consecutive edges -> rx_data 8'h11, 8'h22, 8'h33 two edges later, with rx_new_data high for 3 cycles.
REQ-033 SHALL verify RX stall: VALID=1 with xDATA=8'h5C, rx_hold=1 for 5 cycles -> tx_hold=1 and xDATA=8'h5C held; after rx_hold=0, rx_data=8'h5C with a single rx_new_data pulse.
REQ-034 SHALL verify tx_en dropping during a stall: tx_en 1->0 while tx_hold=1 -> VALID stays 1 until READY, then VALID=0, with no extra word.
REQ-035 SHALL verify alternating tx_en (toggled every cycle for 10 cycles) -> rx_new_data pulses equal to the number of tx_en-high edges, in order, with no duplicates.
REQ-036 SHALL verify, with TXRX_XFER_COUNT_EN, 70000 streamed transfers -> xfer_count = 70000 mod 65536 = 4464.

Source files
------------

// File: rtl/txrx_pkg.sv
// Shared constants for the txrx channel: default data width and transfer counter width.
package txrx_pkg;
    localparam int TXRX_WIDTH = 8;
    localparam int TXRX_CNT_W = 16;
endpackage

// File: rtl/txrx_channel_rx_stage.sv
// RX side of the txrx channel: READY generation, capture register and new-data pulse.
module txrx_rx_stage
    import txrx_pkg::*;
#(
    parameter int WIDTH = TXRX_WIDTH
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_xdata,
    input  logic             rx_hold,
    output logic             READY,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_new_data,
    output logic             o_hs
);
    logic [WIDTH-1:0] r_rx_data;
    logic             r_new;

    // READY drops with reset so no handshake is seen while the channel is held clear
    assign READY       = ~rx_hold & ~ARESET;
    assign o_hs        = i_valid & READY;
    assign rx_data     = r_rx_data;
    assign rx_new_data = r_new;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rx_data <= '0;
            r_new     <= 1'b0;
        end else begin
            r_new <= o_hs;
            if (o_hs)
                r_rx_data <= i_xdata;
        end
    end
endmodule

// File: rtl/txrx_channel.sv
// Valid/ready TX->RX channel with a single-register TX stage.
// Optional handshake counter enabled by defining TXRX_XFER_COUNT_EN.
module txrx_channel
    import txrx_pkg::*;
#(
    parameter int WIDTH = TXRX_WIDTH
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  tx_en,
    input  logic [WIDTH-1:0]      tx_data,
    output logic                  tx_hold,
    output logic                  VALID,
    output logic [WIDTH-1:0]      xDATA,
    output logic                  READY,
    input  logic                  rx_hold,
    output logic [WIDTH-1:0]      rx_data,
    output logic                  rx_new_data,
    output logic [TXRX_CNT_W-1:0] xfer_count
);
    logic             r_valid;
    logic [WIDTH-1:0] r_xdata;
    logic             w_hs;

    assign VALID   = r_valid;
    assign xDATA   = r_xdata;
    assign tx_hold = r_valid & ~READY;

    // The register only reloads when empty or draining, so a held word is never lost
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_valid <= 1'b0;
            r_xdata <= '0;
        end else if (!r_valid || w_hs) begin
            r_valid <= tx_en;
            if (tx_en)
                r_xdata <= tx_data;
        end
    end

    txrx_rx_stage #(.WIDTH(WIDTH)) u_rx (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .i_valid     (r_valid),
        .i_xdata     (r_xdata),
        .rx_hold     (rx_hold),
        .READY       (READY),
        .rx_data     (rx_data),
        .rx_new_data (rx_new_data),
        .o_hs        (w_hs)
    );

`ifdef TXRX_XFER_COUNT_EN
    logic [TXRX_CNT_W-1:0] r_count;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            r_count <= '0;
        else if (w_hs)
            r_count <= r_count + 1'b1;
    end

    assign xfer_count = r_count;
`else
    assign xfer_count = '0;
`endif
endmodule

// File: tb/tb_txrx_channel.sv
// Directed self-checking bench for txrx_channel.
module tb_txrx_channel;
    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        tx_hold;
    logic        VALID;
    logic [7:0]  xDATA;
    logic        READY;
    logic        rx_hold;
    logic [7:0]  rx_data;
    logic        rx_new_data;
    logic [15:0] xfer_count;

    int n_tests = 0;
    int n_fail  = 0;

    txrx_channel #(.WIDTH(8)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .tx_en(tx_en), .tx_data(tx_data),
        .tx_hold(tx_hold), .VALID(VALID), .xDATA(xDATA), .READY(READY),
        .rx_hold(rx_hold), .rx_data(rx_data), .rx_new_data(rx_new_data),
        .xfer_count(xfer_count)
    );

    always #5 ACLK = ~ACLK;

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset();
        ARESET = 1'b1; tx_en = 1'b0; tx_data = 8'h00; rx_hold = 1'b0;
        step(); step();
        ARESET = 1'b0;
        step();
    endtask

    task automatic test_reset();
        ARESET = 1'b1; tx_en = 1'b1; tx_data = 8'hA5; rx_hold = 1'b0;
        step(); step();
        n_tests++; if (VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", VALID); end
        n_tests++; if (READY !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", READY); end
        n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        n_tests++; if (rx_new_data !== 1'b0) begin n_fail++; $display("FAIL reset_rx_new: got %b expected 0", rx_new_data); end
        n_tests++; if (tx_hold !== 1'b0 || xDATA !== 8'h00 || xfer_count !== 16'h0) begin
            n_fail++; $display("FAIL reset_misc: got hold=%b x=%h cnt=%h expected 0/00/0000", tx_hold, xDATA, xfer_count);
        end
        tx_en = 1'b0;
        ARESET = 1'b0;
        step();
        n_tests++; if (READY !== 1'b1 || VALID !== 1'b0) begin
            n_fail++; $display("FAIL post_reset: got ready=%b valid=%b expected 1/0", READY, VALID);
        end
    endtask

    task automatic test_streaming();
        logic [7:0] exp_rx [3];
        exp_rx[0] = 8'h11; exp_rx[1] = 8'h22; exp_rx[2] = 8'h33;
        rx_hold = 1'b0; tx_en = 1'b1; tx_data = 8'h11;
        step();
        n_tests++; if (VALID !== 1'b1 || xDATA !== 8'h11) begin
            n_fail++; $display("FAIL stream_first: got v=%b x=%h expected 1/11", VALID, xDATA);
        end
        tx_data = 8'h22; step();
        n_tests++; if (rx_new_data !== 1'b1 || rx_data !== exp_rx[0]) begin
            n_fail++; $display("FAIL stream_w0: got new=%b d=%h expected 1/%h", rx_new_data, rx_data, exp_rx[0]);
        end
        tx_data = 8'h33; step();
        n_tests++; if (rx_new_data !== 1'b1 || rx_data !== exp_rx[1] || xDATA !== 8'h33) begin
            n_fail++; $display("FAIL stream_w1: got new=%b d=%h x=%h expected 1/%h/33", rx_new_data, rx_data, xDATA, exp_rx[1]);
        end
        tx_en = 1'b0; tx_data = 8'hEE; step();
        n_tests++; if (rx_new_data !== 1'b1 || rx_data !== exp_rx[2] || VALID !== 1'b0) begin
            n_fail++; $display("FAIL stream_w2: got new=%b d=%h v=%b expected 1/%h/0", rx_new_data, rx_data, VALID, exp_rx[2]);
        end
        step();
        n_tests++; if (rx_new_data !== 1'b0 || rx_data !== 8'h33) begin
            n_fail++; $display("FAIL stream_idle: got new=%b d=%h expected 0/33", rx_new_data, rx_data);
        end
`ifndef TXRX_XFER_COUNT_EN
        n_tests++; if (xfer_count !== 16'h0) begin
            n_fail++; $display("FAIL count_tied: got %h expected 0000", xfer_count);
        end
`endif
    endtask

    task automatic test_rx_stall();
        int pulses = 0;
        tx_en = 1'b1; tx_data = 8'h5C; rx_hold = 1'b1;
        step();
        tx_data = 8'h77;
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (tx_hold !== 1'b1 || xDATA !== 8'h5C || rx_new_data !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got h=%b x=%h new=%b expected 1/5c/0", i, tx_hold, xDATA, rx_new_data);
            end
            step();
        end
        rx_hold = 1'b0; tx_en = 1'b0;
        #1;
        n_tests++; if (tx_hold !== 1'b0 || READY !== 1'b1) begin
            n_fail++; $display("FAIL stall_release: got h=%b r=%b expected 0/1", tx_hold, READY);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            if (rx_new_data === 1'b1) pulses++;
        end
        n_tests++; if (rx_data !== 8'h5C || pulses != 1 || VALID !== 1'b0) begin
            n_fail++; $display("FAIL stall_deliver: got d=%h pulses=%0d v=%b expected 5c/1/0", rx_data, pulses, VALID);
        end
    endtask

    task automatic test_tx_drop();
        int pulses = 0;
        tx_en = 1'b1; tx_data = 8'h3C; rx_hold = 1'b1;
        step();
        tx_en = 1'b0; tx_data = 8'h99;
        step(); step();
        n_tests++; if (VALID !== 1'b1 || tx_hold !== 1'b1 || xDATA !== 8'h3C) begin
            n_fail++; $display("FAIL drop_held: got v=%b h=%b x=%h expected 1/1/3c", VALID, tx_hold, xDATA);
        end
        rx_hold = 1'b0;
        step();
        if (rx_new_data === 1'b1) pulses++;
        n_tests++; if (VALID !== 1'b0 || rx_data !== 8'h3C) begin
            n_fail++; $display("FAIL drop_accept: got v=%b d=%h expected 0/3c", VALID, rx_data);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            if (rx_new_data === 1'b1) pulses++;
        end
        n_tests++; if (pulses != 1 || VALID !== 1'b0) begin
            n_fail++; $display("FAIL drop_extra: got pulses=%0d v=%b expected 1/0", pulses, VALID);
        end
    endtask

    task automatic test_alternating();
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        rx_hold = 1'b0;
        for (int i = 0; i < 13; i++) begin
            tx_en   = (i < 10) && (i % 2 == 0);
            tx_data = 8'h40 + 8'(i);
            if (tx_en) exp_q.push_back(tx_data);
            step();
            if (rx_new_data === 1'b1) got_q.push_back(rx_data);
        end
        tx_en = 1'b0;
        n_tests++; if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL alt_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++; if (got_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL alt_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        tx_en = 1'b1; tx_data = 8'hD7; rx_hold = 1'b1;
        step();
        #2 ARESET = 1'b1;
        #1;
        n_tests++; if (VALID !== 1'b0 || READY !== 1'b0 || xDATA !== 8'h00) begin
            n_fail++; $display("FAIL midreset_async: got v=%b r=%b x=%h expected 0/0/00", VALID, READY, xDATA);
        end
        tx_en = 1'b0; rx_hold = 1'b0;
        step();
        ARESET = 1'b0;
        step(); step();
        n_tests++; if (VALID !== 1'b0 || rx_new_data !== 1'b0 || rx_data !== 8'h00) begin
            n_fail++; $display("FAIL midreset_discard: got v=%b new=%b d=%h expected 0/0/00", VALID, rx_new_data, rx_data);
        end
        tx_en = 1'b1; tx_data = 8'h6B;
        step();
        tx_en = 1'b0;
        step();
        n_tests++; if (rx_new_data !== 1'b1 || rx_data !== 8'h6B) begin
            n_fail++; $display("FAIL midreset_resume: got new=%b d=%h expected 1/6b", rx_new_data, rx_data);
        end
    endtask

`ifdef TXRX_XFER_COUNT_EN
    task automatic test_xfer_count();
        do_reset();
        tx_en = 1'b1; rx_hold = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            tx_data = 8'(i);
            step();
        end
        tx_en = 1'b0;
        step(); step();
        n_tests++; if (xfer_count !== 16'd4464) begin
            n_fail++; $display("FAIL xfer_count: got %0d expected 4464", xfer_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_rx_stall();
        test_tx_drop();
        test_alternating();
        test_reset_midop();
`ifdef TXRX_XFER_COUNT_EN
        test_xfer_count();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
